// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and legality helper for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_SAR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Codes 8..15 are reserved.
  function automatic logic is_legal(input logic [3:0] fun);
    return (fun[3] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the execute stage and alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic [3:0]       alufun;
  logic             set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] valE;
  logic             err;
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;

  modport master (
    output in_valid, aluA, aluB, alufun, set_cc, out_ready,
    input  in_ready, out_valid, valE, err, cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  in_valid, aluA, aluB, alufun, set_cc, out_ready,
    output in_ready, out_valid, valE, err, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one partial product per cycle, WIDTH steps, low half kept.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // High during the final step; the product is complete at the following edge.
  assign done    = (cnt_q == CW'(1));
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, multi-cycle multiply and registered condition codes.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] valE_q, valE_d;
  logic             err_q, err_d;
  logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic             mul_cc_q, mul_cc_d;

  logic             in_ready, accept, mul_start, mul_done;
  logic [WIDTH-1:0] product, res;
  logic [SHW-1:0]   shamt;
  logic             ovf;

  assign shamt    = bus.aluB[SHW-1:0];
  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (bus.alufun)
      OP_ADD: begin
        res = bus.aluA + bus.aluB;
        ovf = (bus.aluA[WIDTH-1] == bus.aluB[WIDTH-1]) && (res[WIDTH-1] != bus.aluA[WIDTH-1]);
      end
      OP_SUB: begin
        res = bus.aluA - bus.aluB;
        ovf = (bus.aluA[WIDTH-1] != bus.aluB[WIDTH-1]) && (res[WIDTH-1] != bus.aluA[WIDTH-1]);
      end
      OP_AND:  res = bus.aluA & bus.aluB;
      OP_XOR:  res = bus.aluA ^ bus.aluB;
      OP_SHL:  res = bus.aluA << shamt;
      OP_SHR:  res = bus.aluA >> shamt;
      OP_SAR:  res = $signed(bus.aluA) >>> shamt;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    valE_d      = valE_q;
    err_d       = err_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
    mul_cc_d    = mul_cc_q;
    mul_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.alufun == OP_MUL) begin
            mul_start = 1'b1;
            mul_cc_d  = bus.set_cc;
            state_d   = MUL;
          end else begin
            out_valid_d = 1'b1;
            valE_d      = is_legal(bus.alufun) ? res : '0;
            err_d       = !is_legal(bus.alufun);
            if (bus.set_cc && is_legal(bus.alufun)) begin
              zf_d = (res == '0);
              sf_d = res[WIDTH-1];
              of_d = ovf;
            end
          end
        end
      end
      MUL: begin
        if (mul_done) state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q || bus.out_ready) begin
          out_valid_d = 1'b1;
          valE_d      = product;
          err_d       = 1'b0;
          if (mul_cc_q) begin
            zf_d = (product == '0);
            sf_d = product[WIDTH-1];
            of_d = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      valE_q      <= '0;
      err_q       <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
      mul_cc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      valE_q      <= valE_d;
      err_q       <= err_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
      mul_cc_q    <= mul_cc_d;
    end
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.aluA),
    .b       (bus.aluB),
    .done    (mul_done),
    .product (product)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.valE      = valE_q;
  assign bus.err       = err_q;
  assign bus.cc_zf     = zf_q;
  assign bus.cc_sf     = sf_q;
  assign bus.cc_of     = of_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized ops against a reference model.
module tb_alu_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] val;
    logic         err;
    logic         zf;
    logic         sf;
    logic         of;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

  logic ready_mode = 1'b0;
  logic ready_dir  = 1'b1;
  logic ready_rnd  = 1'b1;
  assign bus.out_ready = ready_mode ? ready_rnd : ready_dir;

  always @(posedge clk) begin
    #1 ready_rnd = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sc);
    exp_t         e;
    logic [W-1:0] r;
    int           sh;
    longint       s;
    longint       lim;
    logic         of;
    lim = 64'sd2147483647;
    sh  = int'(b % W);
    of  = 1'b0;
    r   = '0;
    case (f)
      4'd0: begin r = a + b; s = longint'(int'(a)) + longint'(int'(b)); of = (s > lim) || (s < -lim - 1); end
      4'd1: begin r = a - b; s = longint'(int'(a)) - longint'(int'(b)); of = (s > lim) || (s < -lim - 1); end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      4'd4: r = a << sh;
      4'd5: r = a >> sh;
      4'd6: r = W'(int'(a) >>> sh);
      4'd7: r = a * b;
      default: r = '0;
    endcase
    if (f < 4'd8 && sc) begin
      m_zf = (r == 0);
      m_sf = r[W-1];
      m_of = of;
    end
    e.val = r;
    e.err = (f >= 4'd8);
    e.zf  = m_zf;
    e.sf  = m_sf;
    e.of  = m_of;
    return e;
  endfunction

  // Monitor: a transfer happens at the next rising edge whenever valid && ready now.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got valE 0x%0h with nothing expected at %0t", bus.valE, $time);
        end else begin
          e = q.pop_front();
          chk("valE", bus.valE, e.val);
          chk("err", bus.err, e.err);
          chk("cc_zf", bus.cc_zf, e.zf);
          chk("cc_sf", bus.cc_sf, e.sf);
          chk("cc_of", bus.cc_of, e.of);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic sc);
    int n;
    bus.in_valid = 1'b1;
    bus.alufun   = f;
    bus.aluA     = a;
    bus.aluB     = b;
    bus.set_cc   = sc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end else begin
      q.push_back(model(f, a, b, sc));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    ready_mode = 1'b0;
    ready_dir  = 1'b1;
    n = 0;
    while ((q.size() != 0 || bus.out_valid || !bus.in_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue", q.size(), 0);
  endtask

  initial begin
    int n, errs;
    logic [W-1:0] held;
    logic [3:0]   f;
    logic [W-1:0] a, b;

    bus.in_valid = 1'b0;
    bus.alufun   = '0;
    bus.aluA     = '0;
    bus.aluB     = '0;
    bus.set_cc   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_valE", bus.valE, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_zf", bus.cc_zf, 1);
    chk("rst_sf", bus.cc_sf, 0);
    chk("rst_of", bus.cc_of, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Basic ops back to back
    issue(4'd0, 32'hBE, 32'hAA, 1'b0);
    chk("latency1", bus.out_valid, 1);
    issue(4'd1, 32'hBE, 32'hAA, 1'b0);
    issue(4'd2, 32'hBE, 32'hAA, 1'b0);
    issue(4'd3, 32'hBE, 32'hAA, 1'b0);

    // Flags
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
    issue(4'd1, 32'd5, 32'd5, 1'b1);
    issue(4'd0, 32'd1, 32'd2, 1'b0);

    // Shifts
    issue(4'd4, 32'd1, 32'd31, 1'b1);
    issue(4'd6, 32'h8000_0000, 32'd31, 1'b1);
    issue(4'd5, 32'h8000_0000, 32'd31, 1'b1);
    issue(4'd4, 32'd3, 32'h25, 1'b0);
    wait_drain();

    // MUL latency and in_ready low throughout
    issue(4'd7, 32'h1234, 32'h10, 1'b1);
    n = 0;
    errs = 0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) errs++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", n, W + 1);
    chk("mul_in_ready_low", errs, 0);
    issue(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_drain();

    // Backpressure
    ready_dir = 1'b0;
    issue(4'd0, 32'd10, 32'd20, 1'b1);
    held = bus.valE;
    errs = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.valE !== held || !bus.out_valid || bus.in_ready) errs++;
    end
    chk("bp_stable", errs, 0);
    @(posedge clk);
    #1 ready_dir = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_one_transfer_valid", bus.out_valid, 0);
    chk("bp_one_transfer_q", q.size(), 0);

    // Illegal opcode
    issue(4'hF, 32'd7, 32'd9, 1'b1);
    wait_drain();

    // Randomized traffic with random backpressure
    ready_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      f = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        2: b = a;
        default: ;
      endcase
      issue(f, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_drain();

    // Reset in the middle of a multiply
    issue(4'd7, 32'h55, 32'h77, 1'b1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    q.delete();
    m_zf = 1'b1;
    m_sf = 1'b0;
    m_of = 1'b0;
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_valE", bus.valE, 0);
    chk("mrst_err", bus.err, 0);
    chk("mrst_zf", bus.cc_zf, 1);
    chk("mrst_sf", bus.cc_sf, 0);
    chk("mrst_of", bus.cc_of, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) errs++;
    end
    chk("mrst_no_result", errs, 0);
    @(posedge clk);
    #1;
    issue(4'd0, 32'd2, 32'd3, 1'b1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
